// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin sharing of one p/u -> z multiplier between two stream requesters.
// Defining MUL_ARB_LEN_CHK_EN adds a sticky per-stream length check on len_err.
module mul_arbiter #(
  parameter int N  = 16,
  parameter int QW = 8,
  parameter int UW = 1
) (
  input  logic          clk,
  input  logic          a_rst_n,
  input  logic          r0_p_tvalid,
  output logic          r0_p_tready,
  input  logic [QW-1:0] r0_p_tdata,
  input  logic          r0_p_tlast,
  input  logic          r0_u_tvalid,
  output logic          r0_u_tready,
  input  logic [UW-1:0] r0_u_tdata,
  input  logic          r0_u_tlast,
  output logic          r0_z_tvalid,
  output logic [QW-1:0] r0_z_tdata,
  output logic          r0_z_tlast,
  input  logic          r1_p_tvalid,
  output logic          r1_p_tready,
  input  logic [QW-1:0] r1_p_tdata,
  input  logic          r1_p_tlast,
  input  logic          r1_u_tvalid,
  output logic          r1_u_tready,
  input  logic [UW-1:0] r1_u_tdata,
  input  logic          r1_u_tlast,
  output logic          r1_z_tvalid,
  output logic [QW-1:0] r1_z_tdata,
  output logic          r1_z_tlast,
  output logic          m_p_tvalid,
  input  logic          m_p_tready,
  output logic [QW-1:0] m_p_tdata,
  output logic          m_p_tlast,
  output logic          m_u_tvalid,
  input  logic          m_u_tready,
  output logic [UW-1:0] m_u_tdata,
  output logic          m_u_tlast,
  input  logic          m_z_tvalid,
  input  logic [QW-1:0] m_z_tdata,
  input  logic          m_z_tlast,
  output logic          m_z_tready,
  output logic [1:0]    grant,
  output logic          job_done,
  output logic          len_err
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] rst_sync_q;
  logic rst_n;
  logic [1:0] grant_q, grant_d;
  logic prio_q, prio_d;
  logic p_done_q, p_done_d, u_done_q, u_done_d, z_done_q, z_done_d;
  logic [CW-1:0] p_cnt_q, p_cnt_d, u_cnt_q, u_cnt_d, z_cnt_q, z_cnt_d;
  logic run, sel, p_hs, u_hs, z_beat;
  // reset asserts immediately but releases only after two clk edges
  always_ff @(posedge clk or negedge a_rst_n)
    if (!a_rst_n) rst_sync_q <= '0;
    else rst_sync_q <= {rst_sync_q[0], 1'b1};
  assign rst_n = rst_sync_q[1];
  assign sel = grant_q[1];
  assign m_p_tvalid = run && !p_done_q && (sel ? r1_p_tvalid : r0_p_tvalid);
  assign m_p_tdata = sel ? r1_p_tdata : r0_p_tdata;
  assign m_p_tlast = sel ? r1_p_tlast : r0_p_tlast;
  assign m_u_tvalid = run && !u_done_q && (sel ? r1_u_tvalid : r0_u_tvalid);
  assign m_u_tdata = sel ? r1_u_tdata : r0_u_tdata;
  assign m_u_tlast = sel ? r1_u_tlast : r0_u_tlast;
  assign r0_p_tready = run && grant_q[0] && !p_done_q && m_p_tready;
  assign r1_p_tready = run && grant_q[1] && !p_done_q && m_p_tready;
  assign r0_u_tready = run && grant_q[0] && !u_done_q && m_u_tready;
  assign r1_u_tready = run && grant_q[1] && !u_done_q && m_u_tready;
  assign m_z_tready = 1'b1;
  assign r0_z_tvalid = grant_q[0] && m_z_tvalid;
  assign r1_z_tvalid = grant_q[1] && m_z_tvalid;
  assign r0_z_tdata = m_z_tdata;
  assign r1_z_tdata = m_z_tdata;
  assign r0_z_tlast = m_z_tlast;
  assign r1_z_tlast = m_z_tlast;
  assign grant = grant_q;
  assign p_hs = m_p_tvalid && m_p_tready;
  assign u_hs = m_u_tvalid && m_u_tready;
  assign z_beat = run && m_z_tvalid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      prio_q <= 1'b0;
      p_done_q <= 1'b0;
      u_done_q <= 1'b0;
      z_done_q <= 1'b0;
      p_cnt_q <= '0;
      u_cnt_q <= '0;
      z_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q <= prio_d;
      p_done_q <= p_done_d;
      u_done_q <= u_done_d;
      z_done_q <= z_done_d;
      p_cnt_q <= p_cnt_d;
      u_cnt_q <= u_cnt_d;
      z_cnt_q <= z_cnt_d;
    end
  // prio_q=1 means r1 wins the next tie
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d = prio_q;
    p_done_d = p_done_q | (p_hs & m_p_tlast);
    u_done_d = u_done_q | (u_hs & m_u_tlast);
    z_done_d = z_done_q | (z_beat & m_z_tlast);
    p_cnt_d = p_hs ? p_cnt_q + 1'b1 : p_cnt_q;
    u_cnt_d = u_hs ? u_cnt_q + 1'b1 : u_cnt_q;
    z_cnt_d = (z_beat && !z_done_q) ? z_cnt_q + 1'b1 : z_cnt_q;
    case (state_q)
      IDLE: if (r0_p_tvalid || r1_p_tvalid) begin
        state_d = RUN;
        grant_d = (r0_p_tvalid && r1_p_tvalid) ? (prio_q ? 2'b10 : 2'b01) : {r1_p_tvalid, r0_p_tvalid};
        p_cnt_d = '0;
        u_cnt_d = '0;
        z_cnt_d = '0;
      end
      RUN: if (p_done_d && u_done_d && z_done_d) state_d = DONE;
      DONE: begin
        state_d = IDLE;
        prio_d = grant_q[0];
        grant_d = '0;
        p_done_d = 1'b0;
        u_done_d = 1'b0;
        z_done_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    run = state_q == RUN;
    job_done = state_q == DONE;
  end
`ifdef MUL_ARB_LEN_CHK_EN
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  logic len_err_q, len_err_d;
  assign len_err_d = len_err_q
    | (p_hs && (m_p_tlast != (p_cnt_q == LAST)))
    | (u_hs && (m_u_tlast != (u_cnt_q == LAST)))
    | (z_beat && !z_done_q && (m_z_tlast != (z_cnt_q == LAST)));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) len_err_q <= 1'b0;
    else len_err_q <= len_err_d;
  assign len_err = len_err_q;
`else
  assign len_err = 1'b0;
`endif
endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameters SHALL be: N, default 16, coefficients per polynomial; QW, default 8, p/z coefficient width; UW, default 1, u coefficient width.
REQ-002 Ports SHALL be:
- clk  in  1  single clock.
- a_rst_n  in  1  reset, asynchronous, active-low.
- rK_p_tvalid/rK_p_tready/rK_p_tdata[QW]/rK_p_tlast (K=0,1)  in/out/in/in  requester p streams.
- rK_u_tvalid/rK_u_tready/rK_u_tdata[UW]/rK_u_tlast  in/out/in/in  requester u streams.
- rK_z_tvalid/rK_z_tdata[QW]/rK_z_tlast  out/out/out  requester result streams.
- m_p_tvalid/m_p_tready/m_p_tdata[QW]/m_p_tlast  out/in/out/out  to multiplier p.
- m_u_tvalid/m_u_tready/m_u_tdata[UW]/m_u_tlast  out/in/out/out  to multiplier u.
- m_z_tvalid/m_z_tdata[QW]/m_z_tlast  in/in/in  from multiplier z.
- m_z_tready  out  1  tied 1.
- grant[2]  out  one-hot owner, 0 when idle.
- job_done  out  1  one-cycle pulse per completed job.
- len_err  out  1  sticky length error.
REQ-003 Requester z streams SHALL have no tready; requesters must always accept z.

Function
REQ-004 FSM states SHALL be IDLE, RUN, DONE.
REQ-005 IDLE: requester K SHALL be requesting when rK_p_tvalid=1; when any requests, register grant and enter RUN next cycle.
REQ-006 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester not granted last; after reset, r0 wins the first tie.
REQ-007 RUN: m_p_* SHALL combinationally mirror the granted rK_p_* (tready back), gated off once p_done is set; same for u with u_done.
REQ-008 Non-granted requesters SHALL see tready=0 in all states; all tready=0 in IDLE and DONE.
REQ-009 p_done SHALL set on an m_p handshake with tlast=1; u_done likewise; z_done on m_z_tvalid with m_z_tlast=1.
REQ-010 m_z_* SHALL be routed combinationally to the granted requester's z port whenever grant is nonzero; the other z port SHALL have tvalid=0; m_z_tvalid while grant=0 SHALL be dropped.
REQ-011 RUN SHALL transition to DONE in the cycle after p_done, u_done and z_done are all set; done flags set in the same cycle SHALL all count.
REQ-012 DONE SHALL last one cycle: job_done=1, update the round-robin pointer, clear grant and done flags, return to IDLE.
REQ-013 Per-stream beat counters SHALL be ceil(log2 N) bits and reset to 0 at each RUN entry.
REQ-014 Minimum job-to-job gap SHALL be 2 cycles (DONE, IDLE) after the final z beat.

Reset
REQ-015 a_rst_n low SHALL asynchronously force IDLE, grant=0, job_done=0, len_err=0, round-robin pointer to r0, counters and flags to 0; all tvalid/tready outputs SHALL be 0 except m_z_tready=1.
REQ-016 Reset during RUN SHALL abandon the job with no job_done pulse; release SHALL be synchronous to clk.

Configuration
REQ-017 Macro MUL_ARB_LEN_CHK_EN: when defined, len_err SHALL set if tlast arrives on any stream at a beat index other than N-1, or beat N-1 arrives without tlast; the affected done flag SHALL still follow tlast.
REQ-018 Without MUL_ARB_LEN_CHK_EN, len_err SHALL be tied 0 and no length comparison logic synthesised; beat counters remain.

Verification
REQ-019 Single job: r0 sends 16 p and 16 u beats, multiplier returns 16 z with last -> grant=01 during RUN, r0 gets 16 z beats, one job_done, then grant=00.
REQ-020 Tie: r0 and r1 assert p_tvalid together, repeatedly -> grants alternate 01,10,01,...; r1 blocked (tready=0) while r0 runs.
REQ-021 Backpressure: m_p_tready toggled every cycle -> all 16 p beats delivered in order, no duplicates or drops.
REQ-022 Simultaneous done: p, u last handshakes and z last in same cycle -> DONE next cycle, job_done once.
REQ-023 Length check with MUL_ARB_LEN_CHK_EN: p_tlast on beat 9 -> len_err=1 and stays 1 until reset; without macro -> len_err=0.
REQ-024 Reset mid-RUN at beat 7 -> grant=00, no job_done, next request granted to r0 on a tie.
